// File: rtl/rsc_frame_encoder_if.sv
// Handshake bundle between the RSC encoder, its bit source and the puncturer.
// Latency: none (signal bundle only).
// Backpressure: carries in_valid/in_ready and out_valid/out_ready pairs.
//
// Signals:
//   start                      frame start pulse (source -> encoder)
//   in_bit, in_valid, in_ready information bit handshake
//   out_sys, out_par           systematic / parity pair
//   out_tail, out_last         pair is a tail step / final pair of frame
//   out_valid, out_ready       output pair handshake
//   busy, enc_state            encoder status: not idle, trellis state {r1,r2}
// Modports: master = bit source / pair sink side, slave = encoder side.
interface rsc_frame_encoder_if;
    logic       start;
    logic       in_bit;
    logic       in_valid;
    logic       in_ready;
    logic       out_sys;
    logic       out_par;
    logic       out_tail;
    logic       out_last;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic [1:0] enc_state;

    modport master (
        output start, in_bit, in_valid, out_ready,
        input  in_ready, out_sys, out_par, out_tail, out_last, out_valid,
               busy, enc_state
    );

    modport slave (
        input  start, in_bit, in_valid, out_ready,
        output in_ready, out_sys, out_par, out_tail, out_last, out_valid,
               busy, enc_state
    );
endinterface

// File: rtl/rsc_frame_encoder.sv
// Frame-level 4-state recursive systematic convolutional encoder (turbo constituent).
// Latency: (sys,par) pair for an accepted bit is valid the cycle after acceptance.
// Backpressure: out_valid & !out_ready holds the pair; no bit accepted, no tail step.
//
// Ports:
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   enc        rsc_frame_encoder_if.slave: start, in_bit/in_valid/in_ready,
//              out_sys/out_par/out_tail/out_last/out_valid/out_ready, busy, enc_state
// Parameters: FRAME_LEN information bits per frame, CNT_W bit counter width.
// Build option: define RSC_TAIL_EN to append two trellis-terminating tail pairs.
module rsc_frame_encoder #(
    parameter int FRAME_LEN = 40,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    rsc_frame_encoder_if.slave enc
);

`ifdef RSC_TAIL_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_TAIL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1} state_t;
`endif

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       enc_q, enc_d;      // {r1,r2}
    logic             sys_q, sys_d;
    logic             par_q, par_d;
    logic             last_q, last_d;
    logic             vld_q, vld_d;
`ifdef RSC_TAIL_EN
    logic             tail_q, tail_d;
    logic             tstep_q, tstep_d;  // 0: first tail step pending, 1: second
`endif

    logic             adv;      // output register can take a new pair this cycle
    logic             in_rdy;
    logic             u_w;
    logic             a_w;

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            enc_q   <= 2'b00;
            sys_q   <= 1'b0;
            par_q   <= 1'b0;
            last_q  <= 1'b0;
            vld_q   <= 1'b0;
`ifdef RSC_TAIL_EN
            tail_q  <= 1'b0;
            tstep_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            enc_q   <= enc_d;
            sys_q   <= sys_d;
            par_q   <= par_d;
            last_q  <= last_d;
            vld_q   <= vld_d;
`ifdef RSC_TAIL_EN
            tail_q  <= tail_d;
            tstep_q <= tstep_d;
`endif
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enc_d   = enc_q;
        sys_d   = sys_q;
        par_d   = par_q;
        last_d  = last_q;
        // A taken pair empties the register unless a new one is loaded below.
        vld_d   = vld_q & ~enc.out_ready;
`ifdef RSC_TAIL_EN
        tail_d  = tail_q;
        tstep_d = tstep_q;
`endif
        u_w     = 1'b0;
        a_w     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enc.start) begin
                    state_d = S_DATA;
                    enc_d   = 2'b00;
                    cnt_d   = '0;
                end
            end

            S_DATA: begin
                if (enc.in_valid && in_rdy) begin
                    u_w   = enc.in_bit;
                    a_w   = u_w ^ enc_q[1] ^ enc_q[0];
                    sys_d = u_w;
                    par_d = a_w ^ enc_q[0];
                    vld_d = 1'b1;
                    enc_d = {a_w, enc_q[1]};
                    cnt_d = cnt_q + CNT_W'(1);
`ifdef RSC_TAIL_EN
                    tail_d = 1'b0;
                    last_d = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_TAIL;
                        tstep_d = 1'b0;
                    end
`else
                    last_d = (cnt_q == LAST_IDX);
                    if (cnt_q == LAST_IDX) begin
                        state_d = S_IDLE;
                    end
`endif
                end
            end

`ifdef RSC_TAIL_EN
            S_TAIL: begin
                if (adv) begin
                    // Feeding u = r1^r2 makes the feedback bit a zero, so two
                    // steps shift zeros into both registers and end in state 00.
                    u_w     = enc_q[1] ^ enc_q[0];
                    sys_d   = u_w;
                    par_d   = enc_q[0];
                    tail_d  = 1'b1;
                    last_d  = tstep_q;
                    vld_d   = 1'b1;
                    enc_d   = {1'b0, enc_q[1]};
                    tstep_d = 1'b1;
                    if (tstep_q) begin
                        state_d = S_IDLE;
                    end
                end
            end
`endif

            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        adv    = ~vld_q | enc.out_ready;
        in_rdy = (state_q == S_DATA) & adv;
    end

    assign enc.in_ready  = in_rdy;
    assign enc.out_sys   = sys_q;
    assign enc.out_par   = par_q;
    assign enc.out_last  = last_q;
    assign enc.out_valid = vld_q;
    assign enc.busy      = (state_q != S_IDLE);
    assign enc.enc_state = enc_q;
`ifdef RSC_TAIL_EN
    assign enc.out_tail  = tail_q;
`else
    assign enc.out_tail  = 1'b0;
`endif

endmodule

// File: tb/tb_rsc_frame_encoder.sv
// Self-checking bench for rsc_frame_encoder: two instances (FRAME_LEN 4 and 40)
// share the stimulus, selected by sel; outputs are compared with a frame-level model.
module tb_rsc_frame_encoder;

    typedef logic [3:0] pair_t;  // {sys, par, tail, last}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic sel;
    logic start;
    logic in_bit;
    logic in_valid;
    logic out_ready;

    rsc_frame_encoder_if ifa ();
    rsc_frame_encoder_if ifb ();

    assign ifa.start     = start & ~sel;
    assign ifa.in_bit    = in_bit;
    assign ifa.in_valid  = in_valid & ~sel;
    assign ifa.out_ready = out_ready;
    assign ifb.start     = start & sel;
    assign ifb.in_bit    = in_bit;
    assign ifb.in_valid  = in_valid & sel;
    assign ifb.out_ready = out_ready;

    rsc_frame_encoder #(.FRAME_LEN(4), .CNT_W(3)) dut_a (
        .clk (clk),
        .rst (rst),
        .enc (ifa)
    );

    rsc_frame_encoder #(.FRAME_LEN(40), .CNT_W(6)) dut_b (
        .clk (clk),
        .rst (rst),
        .enc (ifb)
    );

    logic       o_sys, o_par, o_tail, o_last, o_vld, o_in_rdy, o_busy;
    logic [1:0] o_state;
    assign o_sys    = sel ? ifb.out_sys   : ifa.out_sys;
    assign o_par    = sel ? ifb.out_par   : ifa.out_par;
    assign o_tail   = sel ? ifb.out_tail  : ifa.out_tail;
    assign o_last   = sel ? ifb.out_last  : ifa.out_last;
    assign o_vld    = sel ? ifb.out_valid : ifa.out_valid;
    assign o_in_rdy = sel ? ifb.in_ready  : ifa.in_ready;
    assign o_busy   = sel ? ifb.busy      : ifa.busy;
    assign o_state  = sel ? ifb.enc_state : ifa.enc_state;

    int         total = 0;
    int         bad   = 0;
    int         bp_mode = 0;
    int         cyc = 0;
    bit         bits_q[$];
    pair_t      cap_q[$];
    pair_t      exp_q[$];
    logic [1:0] exp_state;

`ifdef RSC_TAIL_EN
    localparam logic [23:0] T1_PAIRS = 24'b1100_0100_0100_0000_1010_1111;
    localparam logic [1:0]  T1_STATE = 2'b00;
`else
    localparam logic [23:0] T1_PAIRS = 24'b0000_0000_1100_0100_0100_0001;
    localparam logic [1:0]  T1_STATE = 2'b10;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Frame-level reference: walk the trellis once per information bit, then
    // (with tail) twice more choosing u so the feedback bit is zero.
    task automatic build_model();
        bit r1, r2, u, a, p;
        int n;
        r1 = 1'b0;
        r2 = 1'b0;
        n  = bits_q.size();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            u = bits_q[i];
            a = u ^ r1 ^ r2;
            p = a ^ r2;
`ifdef RSC_TAIL_EN
            exp_q.push_back({u, p, 1'b0, 1'b0});
`else
            exp_q.push_back({u, p, 1'b0, (i == n - 1)});
`endif
            r2 = r1;
            r1 = a;
        end
`ifdef RSC_TAIL_EN
        for (int t = 0; t < 2; t++) begin
            u = r1 ^ r2;
            a = u ^ r1 ^ r2;
            p = a ^ r2;
            exp_q.push_back({u, p, 1'b1, (t == 1)});
            r2 = r1;
            r1 = a;
        end
`endif
        exp_state = {r1, r2};
    endtask

    function automatic bit ready_now();
        case (bp_mode)
            1:       return !(cyc >= 3 && cyc < 6);
            2:       return ($urandom_range(0, 3) != 0);
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load_bits(input int mode, input int n);
        bits_q.delete();
        for (int i = 0; i < n; i++) begin
            case (mode)
                0:       bits_q.push_back(1'b0);
                1:       bits_q.push_back(i == 0);
                default: bits_q.push_back(bit'($urandom_range(0, 1)));
            endcase
        end
    endtask

    function automatic logic [23:0] pack_cap();
        logic [23:0] g;
        g = '0;
        foreach (cap_q[i]) g = {g[19:0], cap_q[i]};
        return g;
    endfunction

    // Runs one frame on the selected DUT; spur_idx >= 0 pulses start again
    // while that bit is presented (must be ignored while busy).
    task automatic run_frame(input bit s, input int mode, input int spur_idx, input string nm);
        bit accepted;
        sel     = s;
        bp_mode = mode;
        cyc     = 0;
        cap_q.delete();
        build_model();
        start     = 1'b1;
        out_ready = ready_now();
        tick();
        start = 1'b0;
        foreach (bits_q[i]) begin
            in_valid = 1'b1;
            in_bit   = bits_q[i];
            if (i == spur_idx) start = 1'b1;
            accepted = 1'b0;
            for (int k = 0; k < 100 && !accepted; k++) begin
                out_ready = ready_now();
                @(negedge clk);
                accepted = o_in_rdy;
                tick();
                start = 1'b0;
            end
            if (!accepted) check({nm, "_accept_timeout"}, 0, 1);
        end
        in_valid = 1'b0;
        for (int k = 0; k < 400 && cap_q.size() < exp_q.size(); k++) begin
            out_ready = ready_now();
            tick();
        end
        out_ready = 1'b1;
        check({nm, "_npairs"}, cap_q.size(), exp_q.size());
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_pair%0d", nm, i), cap_q[i], exp_q[i]);
        check({nm, "_enc_state"}, o_state, exp_state);
        check({nm, "_busy_end"}, o_busy, 0);
        check({nm, "_vld_end"}, o_vld, 0);
    endtask

    // Output monitor: captures taken pairs, checks hold-under-backpressure.
    logic [4:0] prev;
    bit         hold = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) check("hold_stable", {o_sys, o_par, o_tail, o_last, o_vld}, prev);
            if (o_vld && !out_ready) check("stall_in_ready", o_in_rdy, 0);
            if (o_vld && out_ready) cap_q.push_back({o_sys, o_par, o_tail, o_last});
            hold = o_vld && !out_ready;
            prev = {o_sys, o_par, o_tail, o_last, o_vld};
        end
    end

    initial begin
        rst       = 1'b1;
        sel       = 1'b0;
        start     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        // reset values of both instances: {vld,sys,par,tail,last,busy,in_ready,state}
        check("reset_a", {ifa.out_valid, ifa.out_sys, ifa.out_par, ifa.out_tail, ifa.out_last,
                          ifa.busy, ifa.in_ready, ifa.enc_state}, 0);
        check("reset_b", {ifb.out_valid, ifb.out_sys, ifb.out_par, ifb.out_tail, ifb.out_last,
                          ifb.busy, ifb.in_ready, ifb.enc_state}, 0);
        rst = 1'b0;
        tick();

        // T1: directed frame, full throughput
        load_bits(1, 4);
        run_frame(1'b0, 0, -1, "t1");
        check("t1_literal", pack_cap(), T1_PAIRS);
        check("t1_state_literal", o_state, T1_STATE);

        // T4: three cycles of backpressure mid-frame
        run_frame(1'b0, 1, -1, "t4");
        check("t4_literal", pack_cap(), T1_PAIRS);

        // T5: reset after two accepted bits, then rerun T1
        sel       = 1'b0;
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        tick();
        in_bit = 1'b0;
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        #1;
        check("t5_rst_vld", o_vld, 0);
        check("t5_rst_busy", o_busy, 0);
        check("t5_rst_state", o_state, 0);
        check("t5_rst_in_ready", o_in_rdy, 0);
        tick();
        rst = 1'b0;
        tick();
        run_frame(1'b0, 0, -1, "t5");
        check("t5_literal", pack_cap(), T1_PAIRS);

        // T6: start while busy is ignored; in_valid while idle is ignored
        run_frame(1'b0, 0, 2, "t6");
        check("t6_literal", pack_cap(), T1_PAIRS);
        in_valid = 1'b1;
        in_bit   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t6_idle_in_ready", o_in_rdy, 0);
            check("t6_idle_vld", o_vld, 0);
            tick();
        end
        in_valid = 1'b0;
        check("t6_idle_busy", o_busy, 0);
        check("t6_idle_state", o_state, T1_STATE);

        // T3: all-zero 40-bit frame
        load_bits(0, 40);
        run_frame(1'b1, 0, -1, "t3");

        // random frames with random backpressure on both instances
        for (int f = 0; f < 3; f++) begin
            load_bits(2, 40);
            run_frame(1'b1, 2, -1, $sformatf("rndb%0d", f));
        end
        for (int f = 0; f < 4; f++) begin
            load_bits(2, 4);
            run_frame(1'b0, 2, -1, $sformatf("rnda%0d", f));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
